// File: rtl/pe_unit.sv
// Multiply-accumulate processing element for a systolic matrix-multiply array.
// Define PE_UNIT_SAT_EN to make the accumulator saturate instead of wrapping.
module pe_unit #(
  parameter int DATA_W = 32,
  parameter int RES_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] up_i,
  input  logic [DATA_W-1:0] left_i,
  output logic [DATA_W-1:0] down_o,
  output logic [DATA_W-1:0] right_o,
  output logic [RES_W-1:0]  res_o
);

  logic [DATA_W-1:0]   r_down;
  logic [DATA_W-1:0]   r_right;
  logic [RES_W-1:0]    r_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [RES_W-1:0]    w_prodExt;
  logic [RES_W-1:0]    w_accNext;

  // Full-width product, zero-extended into the accumulator width.
  assign w_prod    = up_i * left_i;
  assign w_prodExt = RES_W'(w_prod);

`ifdef PE_UNIT_SAT_EN
  logic [RES_W:0] w_sum;

  // Any carry out of the accumulator width pins the result at all-ones;
  // once there, every further non-zero product carries again, so it sticks.
  always_comb begin
    w_sum     = {1'b0, r_acc} + {1'b0, w_prodExt};
    w_accNext = w_sum[RES_W-1:0];
    if (w_sum[RES_W]) begin
      w_accNext = {RES_W{1'b1}};
    end
  end
`else
  assign w_accNext = r_acc + w_prodExt;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_down  <= '0;
      r_right <= '0;
      r_acc   <= '0;
    end else begin
      r_down  <= up_i;
      r_right <= left_i;
      r_acc   <= w_accNext;
    end
  end

  assign down_o  = r_down;
  assign right_o = r_right;
  assign res_o   = r_acc;

endmodule

// File: tb/tb_pe_unit.sv
// Directed self-checking bench for pe_unit: reset, accumulate, forwarding,
// full-width product, asynchronous mid-run reset and accumulator overflow.
module tb_pe_unit;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] up_i;
  logic [31:0] left_i;
  logic [31:0] down_o;
  logic [31:0] right_o;
  logic [63:0] res_o;

  int errors = 0;
  int checks = 0;

  pe_unit #(.DATA_W(32), .RES_W(64)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .up_i    (up_i),
    .left_i  (left_i),
    .down_o  (down_o),
    .right_o (right_o),
    .res_o   (res_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    up_i   = '0;
    left_i = '0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    up_i   = 32'd2;
    left_i = 32'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (res_o !== 64'd0) begin
        errors++;
        $display("[TB] FAIL reset_res edge %0d: got %0h want 0", i, res_o);
      end
      checks++;
      if (down_o !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_down edge %0d: got %0h want 0", i, down_o);
      end
      checks++;
      if (right_o !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_right edge %0d: got %0h want 0", i, right_o);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [63:0] expRes [3];
    expRes[0] = 64'd14;
    expRes[1] = 64'd28;
    expRes[2] = 64'd42;
    up_i   = 32'd2;
    left_i = 32'd7;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (res_o !== expRes[i]) begin
        errors++;
        $display("[TB] FAIL accum_res edge %0d: got %0d want %0d", i + 1, res_o, expRes[i]);
      end
      checks++;
      if (down_o !== 32'd2 || right_o !== 32'd7) begin
        errors++;
        $display("[TB] FAIL accum_fwd edge %0d: got down=%0d right=%0d want 2/7", i + 1, down_o, right_o);
      end
    end
  endtask

  task automatic test_async_reset();
    // Pull reset between edges: outputs must clear with no clock edge.
    rst_ni = 1'b0;
    #2;
    checks++;
    if (res_o !== 64'd0 || down_o !== 32'd0 || right_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got res=%0d down=%0d right=%0d want 0/0/0", res_o, down_o, right_o);
    end
    tick();
    rst_ni = 1'b1;
    up_i   = 32'd2;
    left_i = 32'd7;
    tick();
    checks++;
    if (res_o !== 64'd14) begin
      errors++;
      $display("[TB] FAIL async_restart: got %0d want 14", res_o);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] upSeq  [3];
    logic [63:0] expRes [3];
    upSeq[0]  = 32'd5;
    upSeq[1]  = 32'd9;
    upSeq[2]  = 32'd0;
    expRes[0] = 64'd15;
    expRes[1] = 64'd42;
    expRes[2] = 64'd42;
    doReset();
    left_i = 32'd3;
    for (int i = 0; i < 3; i++) begin
      up_i = upSeq[i];
      tick();
      checks++;
      if (down_o !== upSeq[i]) begin
        errors++;
        $display("[TB] FAIL fwd_down step %0d: got %0d want %0d", i, down_o, upSeq[i]);
      end
      checks++;
      if (right_o !== 32'd3) begin
        errors++;
        $display("[TB] FAIL fwd_right step %0d: got %0d want 3", i, right_o);
      end
      checks++;
      if (res_o !== expRes[i]) begin
        errors++;
        $display("[TB] FAIL fwd_res step %0d: got %0d want %0d", i, res_o, expRes[i]);
      end
    end
  endtask

  task automatic test_full_width();
    doReset();
    up_i   = 32'hFFFF_FFFF;
    left_i = 32'hFFFF_FFFF;
    tick();
    up_i   = '0;
    left_i = '0;
    checks++;
    if (res_o !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("[TB] FAIL full_width: got %0h want fffffffe00000001", res_o);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] expFinal;
`ifdef PE_UNIT_SAT_EN
    expFinal = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    expFinal = 64'hFFFF_FFFA_0000_0003;
`endif
    doReset();
    up_i   = 32'hFFFF_FFFF;
    left_i = 32'hFFFF_FFFF;
    repeat (3) tick();
    checks++;
    if (res_o !== expFinal) begin
      errors++;
      $display("[TB] FAIL overflow: got %0h want %0h", res_o, expFinal);
    end
    // Zero operand holds the accumulator while forwarding still updates.
    up_i   = 32'd0;
    left_i = 32'd11;
    tick();
    checks++;
    if (res_o !== expFinal) begin
      errors++;
      $display("[TB] FAIL zero_hold: got %0h want %0h", res_o, expFinal);
    end
    checks++;
    if (down_o !== 32'd0 || right_o !== 32'd11) begin
      errors++;
      $display("[TB] FAIL zero_fwd: got down=%0d right=%0d want 0/11", down_o, right_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    up_i   = '0;
    left_i = '0;
    #1;
    test_reset();
    test_accumulate();
    test_async_reset();
    test_forwarding();
    test_full_width();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
